// File: rtl/sound_frame_seq_if.sv
// Bundle of sequencer control inputs and strobe outputs for sound_frame_seq.
// master drives enable/trigger, slave is the sequencer itself.
interface sound_frame_seq_if;
   logic       sound_enable;
   logic [3:0] trigger;
   logic [2:0] step;
   logic       clk_length;
   logic       clk_sweep;
   logic [3:0] env_clk;
   logic [3:0] ch_start;
   logic       len_skip;

   modport master (
      output sound_enable, trigger,
      input  step, clk_length, clk_sweep, env_clk, ch_start, len_skip
   );

   modport slave (
      input  sound_enable, trigger,
      output step, clk_length, clk_sweep, env_clk, ch_start, len_skip
   );
endinterface

// File: rtl/sound_frame_seq.sv
// APU frame sequencer: 512 Hz tick, 8-step length/sweep/envelope strobes, trigger start pulses.
// Define FS_EXT_DIV_EN to tick from falling edges of an external div_bit instead of the prescaler.
module sound_frame_seq #(
   parameter int DIV_COUNT = 8192,
   parameter int DIV_WIDTH = 13
) (
   input  logic clk,
   input  logic rst,
`ifdef FS_EXT_DIV_EN
   input  logic div_bit,
`endif
   sound_frame_seq_if.slave bus
);

   logic [2:0] step_q;
   logic       clk_length_q;
   logic       clk_sweep_q;
   logic [3:0] env_clk_q;
   logic [3:0] ch_start_q;
   logic       tick;

`ifdef FS_EXT_DIV_EN
   logic div_prev;
   assign tick = div_prev & ~div_bit;
`else
   logic [DIV_WIDTH-1:0] prescaler;
   assign tick = (prescaler == DIV_WIDTH'(DIV_COUNT - 1));
`endif

   always_ff @(posedge clk) begin
      if (rst || !bus.sound_enable) begin
`ifdef FS_EXT_DIV_EN
         div_prev     <= 1'b0;
`else
         prescaler    <= '0;
`endif
         step_q       <= 3'd0;
         clk_length_q <= 1'b0;
         clk_sweep_q  <= 1'b0;
         env_clk_q    <= 4'b0000;
         ch_start_q   <= 4'b0000;
      end else begin
`ifdef FS_EXT_DIV_EN
         div_prev     <= div_bit;
`else
         prescaler    <= tick ? '0 : prescaler + 1'b1;
`endif
         ch_start_q   <= bus.trigger;
         if (tick) begin
            clk_length_q <= ~step_q[0];
            clk_sweep_q  <= (step_q == 3'd2) || (step_q == 3'd6);
            // A channel started this same cycle skips its envelope step.
            env_clk_q    <= (step_q == 3'd7) ? (4'b1011 & ~bus.trigger) : 4'b0000;
            step_q       <= step_q + 3'd1;
         end else begin
            clk_length_q <= 1'b0;
            clk_sweep_q  <= 1'b0;
            env_clk_q    <= 4'b0000;
         end
      end
   end

   assign bus.step       = step_q;
   assign bus.clk_length = clk_length_q;
   assign bus.clk_sweep  = clk_sweep_q;
   assign bus.env_clk    = env_clk_q;
   assign bus.ch_start   = ch_start_q;
   assign bus.len_skip   = step_q[0];

endmodule

// File: tb/tb_sound_frame_seq.sv
// Self-checking bench for sound_frame_seq with a cycle-level reference model of the step table.
// Also builds with FS_EXT_DIV_EN defined, driving div_bit with a period-6 square wave.
module tb_sound_frame_seq;
   localparam int DC = 4;

   logic clk = 1'b0;
   logic rst;
   logic div_bit;
   int   errors = 0;
   int   checks = 0;
   int   g_cyc  = 0;

   sound_frame_seq_if bus ();

   sound_frame_seq #(.DIV_COUNT(DC), .DIV_WIDTH(2)) dut (
      .clk     (clk),
      .rst     (rst),
`ifdef FS_EXT_DIV_EN
      .div_bit (div_bit),
`endif
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Step table: what each step clocks.
   bit         len_tab[8]   = '{1, 0, 1, 0, 1, 0, 1, 0};
   bit         sweep_tab[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
   logic [3:0] env_tab[8]   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1011};

   int         m_cnt;
   int         m_step;
   bit         m_dprev;
   logic       m_len, m_sweep;
   logic [3:0] m_env, m_start;

   function automatic bit div_at(input int c);
      return ((c / 3) % 2) == 1;
   endfunction

   function automatic bit tick_next();
`ifdef FS_EXT_DIV_EN
      return m_dprev && !div_at(g_cyc);
`else
      return (m_cnt % DC) == DC - 1;
`endif
   endfunction

   task automatic model_edge(input bit r, input bit en, input logic [3:0] tr, input bit dv);
      bit t;
      if (r || !en) begin
         m_cnt = 0; m_step = 0; m_dprev = 0;
         m_len = 0; m_sweep = 0; m_env = 0; m_start = 0;
      end else begin
`ifdef FS_EXT_DIV_EN
         t = m_dprev && !dv;
`else
         t = (m_cnt % DC) == DC - 1;
`endif
         m_dprev = dv;
         m_cnt++;
         m_start = tr;
         if (t) begin
            m_len   = len_tab[m_step];
            m_sweep = sweep_tab[m_step];
            m_env   = env_tab[m_step] & ~tr;
            m_step  = (m_step + 1) % 8;
         end else begin
            m_len = 0; m_sweep = 0; m_env = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit r, input bit en, input logic [3:0] tr);
      @(negedge clk);
      rst = r;
      bus.sound_enable = en;
      bus.trigger = tr;
      div_bit = div_at(g_cyc);
      @(posedge clk);
      model_edge(r, en, tr, div_bit);
      g_cyc++;
      #1;
      chk("step",       {29'b0, bus.step},       m_step[31:0]);
      chk("clk_length", {31'b0, bus.clk_length}, {31'b0, m_len});
      chk("clk_sweep",  {31'b0, bus.clk_sweep},  {31'b0, m_sweep});
      chk("env_clk",    {28'b0, bus.env_clk},    {28'b0, m_env});
      chk("ch_start",   {28'b0, bus.ch_start},   {28'b0, m_start});
      chk("len_skip",   {31'b0, bus.len_skip},   {31'b0, m_step[0]});
   endtask

   initial begin
      int edges;
      logic [3:0] tr;
      bit r, en;

      rst = 1'b1; bus.sound_enable = 1'b0; bus.trigger = 4'b0; div_bit = 1'b0;
      model_edge(1, 0, 0, 0);
      cyc(1, 0, 4'b0000);
      cyc(1, 0, 4'b0000);

      // First tick after enable.
      edges = 0;
      for (int k = 1; k <= 40; k++) begin
         cyc(0, 1, 4'b0000);
         if (bus.clk_length === 1'b1) begin edges = k; break; end
      end
`ifndef FS_EXT_DIV_EN
      chk("first_tick_edges", edges, DC);
`else
      chk("first_tick_found", {31'b0, edges != 0}, 32'd1);
`endif
      chk("step_after_first", {29'b0, bus.step}, 32'd1);

      // Eight more ticks of the table.
      for (int k = 0; k < 8 * 6 + 2; k++) cyc(0, 1, 4'b0000);

      // Single trigger at an arbitrary time.
      for (int k = 0; k < int'($urandom_range(0, 5)); k++) cyc(0, 1, 4'b0000);
      cyc(0, 1, 4'b0001);
      chk("trig_pulse", {28'b0, bus.ch_start}, 32'h1);
      cyc(0, 1, 4'b0000);
      chk("trig_one_cycle", {28'b0, bus.ch_start}, 32'h0);

      // Trigger coinciding with the step-7 envelope strobe.
      edges = 0;
      for (int k = 0; k < 100; k++) begin
         if (m_step == 7 && tick_next()) begin edges = 1; break; end
         cyc(0, 1, 4'b0000);
      end
      chk("step7_reached", edges, 32'd1);
      cyc(0, 1, 4'b1001);
      chk("prio_env", {28'b0, bus.env_clk}, 32'b0010);
      chk("prio_start", {28'b0, bus.ch_start}, 32'b1001);

      // Enable dropped at step 5 for three cycles.
      for (int k = 0; k < 100 && m_step != 5; k++) cyc(0, 1, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 4'b1111);
         chk("dis_step", {29'b0, bus.step}, 32'd0);
         chk("dis_start", {28'b0, bus.ch_start}, 32'd0);
      end
      edges = 0;
      for (int k = 1; k <= 40; k++) begin
         cyc(0, 1, 4'b0000);
         if (bus.clk_length === 1'b1) begin edges = k; break; end
      end
`ifndef FS_EXT_DIV_EN
      chk("reen_tick_edges", edges, DC);
`else
      chk("reen_tick_found", {31'b0, edges != 0}, 32'd1);
`endif
      chk("reen_step", {29'b0, bus.step}, 32'd1);

      // Reset mid-sequence.
      for (int k = 0; k < 100 && m_step != 3; k++) cyc(0, 1, 4'b0000);
      cyc(1, 1, 4'b0110);
      chk("rst_step", {29'b0, bus.step}, 32'd0);

      // Random traffic.
      for (int k = 0; k < 600; k++) begin
         r  = ($urandom_range(0, 199) == 0);
         en = ($urandom_range(0, 79) != 0);
         tr = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
         cyc(r, en, tr);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
